// File: rtl/generator_seq.sv
// rtl/generator_seq.sv - time-multiplexed two-layer fixed-point generator with one shared MAC
module generator_seq #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int N_INPUT  = 2,
    parameter int N_HIDDEN = 3,
    parameter int N_OUTPUT = 9
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_INPUT*WIDTH-1:0]             a_in,
    input  logic [1:0]                           hid_mode,
    input  logic                                 out_mode,
    input  logic [N_INPUT*N_HIDDEN*WIDTH-1:0]    w_L2,
    input  logic [N_HIDDEN*WIDTH-1:0]            b_L2,
    input  logic [N_HIDDEN*N_OUTPUT*WIDTH-1:0]   w_L3,
    input  logic [N_OUTPUT*WIDTH-1:0]            b_L3,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [N_OUTPUT*WIDTH-1:0]            y_out
);

    localparam int FAN_MAX = (N_INPUT > N_HIDDEN) ? N_INPUT : N_HIDDEN;
    localparam int AW      = 2*WIDTH + $clog2(FAN_MAX) + 1;
    localparam int CNT_MAX = (FAN_MAX > N_OUTPUT) ? FAN_MAX : N_OUTPUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_L2   = 2'd1;
    localparam logic [1:0] ST_L3   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]               state;
    logic [CW-1:0]            nidx;
    logic [CW-1:0]            tidx;
    logic signed [AW-1:0]     acc;
    logic signed [WIDTH-1:0]  a_reg [N_INPUT];
    logic signed [WIDTH-1:0]  hid   [N_HIDDEN];
    logic signed [WIDTH-1:0]  y_reg [N_OUTPUT];
    logic [1:0]               hmode;
    logic                     omode;

    int                       fan_in;
    int                       last_n;
    int                       widx;
    logic signed [WIDTH-1:0]  mac_x;
    logic signed [WIDTH-1:0]  mac_w;
    logic signed [WIDTH-1:0]  bias;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]     prod_ext;
    logic signed [AW:0]       biased;
    logic signed [AW:0]       shifted;
    logic signed [WIDTH-1:0]  sat_s;
    logic signed [WIDTH-1:0]  hid_act;
    logic signed [WIDTH-1:0]  out_act;
    logic                     finalize;

    assign in_ready = (state == ST_IDLE);

    // Operand selection: the same MAC serves both layers, steered by state and counters.
    always_comb begin
        fan_in = (state == ST_L3) ? N_HIDDEN : N_INPUT;
        last_n = (state == ST_L3) ? N_OUTPUT - 1 : N_HIDDEN - 1;
        widx   = int'(nidx) * fan_in + int'(tidx);
        mac_x  = '0;
        mac_w  = '0;
        bias   = '0;
        if (state == ST_L3) begin
            for (int j = 0; j < N_HIDDEN; j++)
                if (int'(tidx) == j) mac_x = hid[j];
            for (int f = 0; f < N_HIDDEN*N_OUTPUT; f++)
                if (widx == f) mac_w = w_L3[f*WIDTH +: WIDTH];
            for (int k = 0; k < N_OUTPUT; k++)
                if (int'(nidx) == k) bias = b_L3[k*WIDTH +: WIDTH];
        end else begin
            for (int j = 0; j < N_INPUT; j++)
                if (int'(tidx) == j) mac_x = a_reg[j];
            for (int f = 0; f < N_INPUT*N_HIDDEN; f++)
                if (widx == f) mac_w = w_L2[f*WIDTH +: WIDTH];
            for (int i = 0; i < N_HIDDEN; i++)
                if (int'(nidx) == i) bias = b_L2[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        prod     = mac_x * mac_w;
        prod_ext = {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        finalize = (int'(tidx) == fan_in);
        biased   = {acc[AW-1], acc} + ({{(AW+1-WIDTH){bias[WIDTH-1]}}, bias} <<< FRAC);
        shifted  = biased >>> FRAC;
        // In range iff every bit above the result sign bit matches it.
        if ((&shifted[AW:WIDTH-1]) || !(|shifted[AW:WIDTH-1]))
            sat_s = shifted[WIDTH-1:0];
        else
            sat_s = shifted[AW] ? SAT_MIN : SAT_MAX;

        case (hmode)
            2'd1:    hid_act = sat_s[WIDTH-1] ? '0 : sat_s;
            2'd2:    hid_act = sat_s[WIDTH-1] ? (sat_s >>> 3) : sat_s;
            default: hid_act = sat_s;
        endcase

        out_act = sat_s;
        if (omode) begin
            if (sat_s > ONE)          out_act = ONE;
            else if (sat_s < NEG_ONE) out_act = NEG_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            nidx      <= '0;
            tidx      <= '0;
            acc       <= '0;
            hmode     <= '0;
            omode     <= 1'b0;
            out_valid <= 1'b0;
            for (int j = 0; j < N_INPUT; j++)  a_reg[j] <= '0;
            for (int i = 0; i < N_HIDDEN; i++) hid[i]   <= '0;
            for (int k = 0; k < N_OUTPUT; k++) y_reg[k] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int j = 0; j < N_INPUT; j++)
                            a_reg[j] <= a_in[j*WIDTH +: WIDTH];
                        hmode <= hid_mode;
                        omode <= out_mode;
                        nidx  <= '0;
                        tidx  <= '0;
                        state <= ST_L2;
                    end
                end
                ST_L2, ST_L3: begin
                    if (finalize) begin
                        if (state == ST_L2) begin
                            for (int i = 0; i < N_HIDDEN; i++)
                                if (int'(nidx) == i) hid[i] <= hid_act;
                        end else begin
                            for (int k = 0; k < N_OUTPUT; k++)
                                if (int'(nidx) == k) y_reg[k] <= out_act;
                        end
                        tidx <= '0;
                        if (int'(nidx) == last_n) begin
                            nidx <= '0;
                            if (state == ST_L2) begin
                                state <= ST_L3;
                            end else begin
                                state     <= ST_DONE;
                                out_valid <= 1'b1;
                            end
                        end else begin
                            nidx <= nidx + 1'b1;
                        end
                    end else begin
                        // First MAC of a neuron overwrites, which clears the previous sum.
                        acc  <= (tidx == '0) ? prod_ext : acc + prod_ext;
                        tidx <= tidx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_OUTPUT; k++) begin : g_yout
        assign y_out[k*WIDTH +: WIDTH] = y_reg[k];
    end

endmodule

// File: tb/tb_generator_seq.sv
// tb/tb_generator_seq.sv - randomized self-checking bench for generator_seq against a reference model
module tb_generator_seq;

    localparam int W   = 32;
    localparam int NI  = 2;
    localparam int NH  = 3;
    localparam int NO  = 9;
    localparam int LAT = 45;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NI*W-1:0]   a_in = '0;
    logic [1:0]        hid_mode = 2'd0;
    logic              out_mode = 1'b0;
    logic [NI*NH*W-1:0] w_l2 = '0;
    logic [NH*W-1:0]   b_l2 = '0;
    logic [NH*NO*W-1:0] w_l3 = '0;
    logic [NO*W-1:0]   b_l3 = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NO*W-1:0]   y_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    generator_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in),
        .hid_mode(hid_mode), .out_mode(out_mode),
        .w_L2(w_l2), .b_L2(b_l2), .w_L3(w_l3), .b_L3(b_l3),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // floor((acc + b*2^16) / 2^16), then clip to the signed 32-bit range
    function automatic logic signed [31:0] fin(input logic signed [127:0] acc, input logic signed [31:0] b);
        logic signed [127:0] bb, t;
        bb = b;
        t  = (acc + bb * 128'sd65536) >>> 16;
        if (t > 128'sd2147483647)  return 32'sh7FFFFFFF;
        if (t < -128'sd2147483648) return 32'sh80000000;
        return t[31:0];
    endfunction

    function automatic logic [NO*W-1:0] model(input logic [NI*W-1:0] a, input logic [1:0] hm, input logic om);
        logic signed [31:0]  h [NH];
        logic signed [127:0] acc, x, w;
        logic signed [31:0]  s;
        logic [NO*W-1:0]     y;
        y = '0;
        for (int i = 0; i < NH; i++) begin
            acc = 0;
            for (int j = 0; j < NI; j++) begin
                x = $signed(a[j*W +: W]);
                w = $signed(w_l2[(NI*i+j)*W +: W]);
                acc += x * w;
            end
            s = fin(acc, $signed(b_l2[i*W +: W]));
            if (hm == 2'd1 && s < 0) s = 0;
            if (hm == 2'd2 && s < 0) s = s >>> 3;
            h[i] = s;
        end
        for (int k = 0; k < NO; k++) begin
            acc = 0;
            for (int j = 0; j < NH; j++) begin
                x = h[j];
                w = $signed(w_l3[(NH*k+j)*W +: W]);
                acc += x * w;
            end
            s = fin(acc, $signed(b_l3[k*W +: W]));
            if (om) begin
                if (s > 32'sd65536)  s = 32'sd65536;
                if (s < -32'sd65536) s = -32'sd65536;
            end
            y[k*W +: W] = s;
        end
        return y;
    endfunction

    // mostly small values around +-4.0, with occasional full-range values to reach saturation
    function automatic logic [31:0] rnd_fix();
        if ($urandom_range(0, 3) == 0) return $urandom();
        return 32'($urandom_range(0, 32'h80000)) - 32'h40000;
    endfunction

    task automatic rand_cfg();
        for (int f = 0; f < NI*NH; f++) w_l2[f*W +: W] = rnd_fix();
        for (int f = 0; f < NH; f++)    b_l2[f*W +: W] = rnd_fix();
        for (int f = 0; f < NH*NO; f++) w_l3[f*W +: W] = rnd_fix();
        for (int f = 0; f < NO; f++)    b_l3[f*W +: W] = rnd_fix();
    endtask

    task automatic run_frame(input string tag, input logic [NI*W-1:0] a, input logic [1:0] hm,
                             input logic om, input bit accept, output logic [NO*W-1:0] exp);
        int cyc;
        exp = model(a, hm, om);
        @(negedge clk);
        check_val({tag, " in_ready"}, 64'(in_ready), 64'd1);
        a_in = a; hid_mode = hm; out_mode = om; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid) break;
        end
        check_val({tag, " latency"}, 64'(cyc), 64'(LAT));
        for (int k = 0; k < NO; k++)
            check_val($sformatf("%s y[%0d]", tag, k), 64'(y_out[k*W +: W]), 64'(exp[k*W +: W]));
        if (accept) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            check_val({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
            check_val({tag, " in_ready back"}, 64'(in_ready), 64'd1);
        end
    endtask

    logic [NO*W-1:0] exp_y;
    logic [NO*W-1:0] exp_q [$];
    logic [NO*W-1:0] e;
    logic [NI*W-1:0] fa [3];
    logic [1:0]      fhm [3];
    logic            fom [3];

    initial begin
        int cyc, sent, got, last;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset in_ready", 64'(in_ready), 64'd1);
        check_val("reset out_valid", 64'(out_valid), 64'd0);
        check_val("reset y_out zero", 64'(y_out == '0), 64'd1);
        @(negedge clk) rst = 1'b0;

        w_l2 = {(NI*NH){32'h00010000}};
        w_l3 = {(NH*NO){32'h00010000}};
        b_l2 = '0; b_l3 = '0;
        run_frame("ident", {32'h00020000, 32'h00010000}, 2'd0, 1'b0, 1'b1, exp_y);
        check_val("ident const", 64'(y_out[8*W +: W]), 64'h00090000);
        run_frame("ident_tanh", {32'h00020000, 32'h00010000}, 2'd0, 1'b1, 1'b1, exp_y);
        check_val("ident_tanh const", 64'(y_out[0 +: W]), 64'h00010000);

        b_l3 = {NO{32'h00008000}};
        run_frame("relu", {32'hFFFF0000, 32'hFFFF0000}, 2'd1, 1'b0, 1'b1, exp_y);
        check_val("relu const", 64'(y_out[0 +: W]), 64'h00008000);
        run_frame("leaky", {32'hFFFF0000, 32'hFFFF0000}, 2'd2, 1'b0, 1'b1, exp_y);
        check_val("leaky const", 64'(y_out[0 +: W]), 64'hFFFFC000);

        b_l3 = '0;
        run_frame("sat_pos", {32'h7FFF0000, 32'h7FFF0000}, 2'd0, 1'b0, 1'b1, exp_y);
        check_val("sat_pos const", 64'(y_out[0 +: W]), 64'h7FFFFFFF);
        run_frame("sat_neg", {32'h80010000, 32'h80010000}, 2'd0, 1'b0, 1'b1, exp_y);
        check_val("sat_neg const", 64'(y_out[0 +: W]), 64'h80000000);

        rand_cfg();
        run_frame("bp", {rnd_fix(), rnd_fix()}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, exp_y);
        a_in = {rnd_fix(), rnd_fix()};
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val($sformatf("bp out_valid c%0d", c), 64'(out_valid), 64'd1);
            check_val($sformatf("bp in_ready c%0d", c), 64'(in_ready), 64'd0);
            check_val($sformatf("bp y_out held c%0d", c), 64'(y_out == exp_y), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("bp out_valid after", 64'(out_valid), 64'd0);
        check_val("bp in_ready after", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        check_val("bp no capture", 64'(in_ready), 64'd1);
        check_val("bp y_out kept", 64'(y_out == exp_y), 64'd1);

        rand_cfg();
        @(negedge clk);
        a_in = {rnd_fix(), rnd_fix()}; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrst out_valid", 64'(out_valid), 64'd0);
        check_val("midrst in_ready", 64'(in_ready), 64'd1);
        check_val("midrst y_out zero", 64'(y_out == '0), 64'd1);
        @(negedge clk) rst = 1'b0;
        run_frame("after_rst", {rnd_fix(), rnd_fix()}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, exp_y);

        for (int r = 0; r < 8; r++) begin
            rand_cfg();
            run_frame($sformatf("rand%0d", r), {rnd_fix(), rnd_fix()},
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, exp_y);
        end

        rand_cfg();
        for (int i = 0; i < 3; i++) begin
            fa[i]  = {rnd_fix(), rnd_fix()};
            fhm[i] = 2'($urandom_range(0, 3));
            fom[i] = 1'($urandom_range(0, 1));
        end
        cyc = 0; sent = 0; got = 0; last = -1;
        out_ready = 1'b1;
        while (got < 3 && cyc < 400) begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("b2b unexpected frame", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < NO; k++)
                        check_val($sformatf("b2b%0d y[%0d]", got, k), 64'(y_out[k*W +: W]), 64'(e[k*W +: W]));
                end
                if (last >= 0) check_val($sformatf("b2b%0d spacing", got), 64'(cyc - last), 64'd47);
                last = cyc;
                got++;
            end
            if (in_ready) begin
                if (sent < 3) begin
                    a_in = fa[sent]; hid_mode = fhm[sent]; out_mode = fom[sent];
                    exp_q.push_back(model(fa[sent], fhm[sent], fom[sent]));
                    in_valid = 1'b1;
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_val("b2b handshakes", 64'(got), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/generator_seq.md
Name: generator_seq

Overview:
- Time-multiplexed, parametrised successor of the two-layer fully connected generator.
- Computes N_INPUT -> N_HIDDEN -> N_OUTPUT in signed fixed point using a single shared multiply-accumulate unit, sequenced by an FSM.
- Exchanges frames over valid/ready handshakes, so it slots into the streaming GAN datapath in place of the combinational generator.
- Adds run-time-selectable activations, rounding-free saturation, and output hold under backpressure.

Parameters:
- WIDTH, 32, sample/weight/bias width (signed, two's complement).
- FRAC, 16, fractional bits (Q(WIDTH-FRAC).FRAC).
- N_INPUT, 2, layer-2 fan-in.
- N_HIDDEN, 3, layer-2 neuron count (layer-3 fan-in).
- N_OUTPUT, 9, layer-3 neuron count (flattened output image, row-major).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame.
- a_in  in  N_INPUT*WIDTH  input vector; element j at [j*WIDTH +: WIDTH].
- hid_mode  in  2  hidden activation: 0 identity, 1 ReLU, 2 leaky ReLU (x>>>3 when negative), 3 is treated as identity.
- out_mode  in  1  output activation: 0 identity, 1 hard-tanh (clamp to [-1.0, +1.0]).
- w_L2  in  N_INPUT*N_HIDDEN*WIDTH  weight j of neuron i at [(N_INPUT*i+j)*WIDTH +: WIDTH].
- b_L2  in  N_HIDDEN*WIDTH  bias i at [i*WIDTH +: WIDTH].
- w_L3  in  N_HIDDEN*N_OUTPUT*WIDTH  weight j of neuron k at [(N_HIDDEN*k+j)*WIDTH +: WIDTH].
- b_L3  in  N_OUTPUT*WIDTH  bias k at [k*WIDTH +: WIDTH].
- out_valid  out  1  y_out holds a complete frame.
- out_ready  in  1  downstream accepts the frame.
- y_out  out  N_OUTPUT*WIDTH  output vector; element k at [k*WIDTH +: WIDTH].

Behaviour:
- Reset (async, asynchronous assert): state IDLE; in_ready=1; out_valid=0; y_out=0; hidden buffer, accumulator and counters cleared.
- FSM states: IDLE, L2, L3, DONE.
  - IDLE: in_ready=1. An in_valid&&in_ready edge captures a_in, hid_mode and out_mode into registers, then moves to L2.
  - L2: for each neuron i=0..N_HIDDEN-1, run N_INPUT MAC cycles followed by 1 finalize cycle that writes hid[i]. After the last neuron, move to L3.
  - L3: same pattern over hid[], fan-in N_HIDDEN; the finalize cycle writes y_out element k. After the last neuron, move to DONE.
  - DONE: out_valid=1 and y_out is stable. On an out_valid&&out_ready edge, clear out_valid and return to IDLE.
- in_ready = (state==IDLE). Frames are never overlapped.
- Weights and biases are not registered. They must stay stable from input handshake until out_valid.
- Latency: input handshake at edge E0 gives out_valid high after edge E0+L, where L = N_HIDDEN*(N_INPUT+1) + N_OUTPUT*(N_HIDDEN+1). Default L = 45. Minimum frame period is L+2 = 47 cycles.
- Arithmetic:
  - Products are full 2*WIDTH signed.
  - Accumulator is 2*WIDTH+clog2(max fan-in)+1 bits and is cleared at the first MAC of each neuron.
  - Finalize: s = (acc + (b <<< FRAC)) >>> FRAC, using an arithmetic shift (floor). s is then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1], then the activation is applied.
  - Hard-tanh bounds are ±(1<<FRAC).
  - Leaky ReLU output on a saturated minimum is -2^(WIDTH-1)>>>3.
- y_out is updated only by finalize cycles. It holds the previous frame's values until overwritten, and is constant throughout DONE.
- A reset mid-operation aborts the frame immediately with no partial output flagged: out_valid stays 0 and in_ready is 1 after reset release.
- in_valid asserted in any non-IDLE state is ignored; no capture, no error.
- out_ready outside DONE has no effect.

Test Plan:
- Identity pass: a=(0x00010000, 0x00020000), all w=0x00010000, all b=0, hid_mode=0, out_mode=0. Expect every y=0x00090000 with out_valid rising exactly 45 cycles after the input handshake. The same run with out_mode=1 gives every y=0x00010000.
- ReLU clamp: a=(0xFFFF0000, 0xFFFF0000), w=1.0, b_L2=0, b_L3=0x00008000, hid_mode=1. Hidden values are 0, so every y=0x00008000. With hid_mode=2, hidden=0xFFFFC000 and every y=0xFFFF4000+0x00008000=0xFFFFC000.
- Saturation: a=(0x7FFF0000, 0x7FFF0000), w=1.0, b=0, identity modes. Hidden saturates to 0x7FFFFFFF and every y=0x7FFFFFFF. The negated inputs give 0x80000000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1. y_out stays constant, out_valid stays 1, in_ready stays 0, and no second frame is captured. Raising out_ready gives an out handshake, then in_ready=1 on the next cycle.
- Reset mid-frame: pulse rst during cycle 20 of L2/L3. out_valid=0, y_out=0 and in_ready=1 immediately. A new frame afterwards completes in 45 cycles with correct values.
- Back-to-back: in_valid and out_ready held high with 3 distinct frames. Expect 3 out handshakes spaced 47 cycles apart, each y_out matching its own frame.
